instr_loader: RTL and testbench

Program loader that fills the instruction memory through its 16-bit paired-byte write port. Accepts a byte stream over a valid/ready handshake, packs consecutive bytes little-endian into 16-bit words, and issues one write strobe per pair at even-stepped addresses. Holds the core off the instruction memory while loading and reports completion or a length error.

---
 rtl/instr_pkg.sv | 20 ++
 rtl/instr_loader.sv | 132 +++++++++++++
 tb/tb_instr_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared opcode constants and loader state encoding
//
// Purpose: opcode values shared by the instruction memory, control unit and
// loader, plus the loader's state enum.
// Ports: none (package).
package instr_pkg;

  // Opcode constants; the loader only needs the endpoints of the list.
  localparam int LDACI = 0;
  localparam int NOP   = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WRITE,
    ST_FIN
  } load_state_e;

endpackage

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader into 16-bit instruction memory
//
// Purpose: packs a valid/ready byte stream little-endian into 2-byte words and
// writes them to instruction memory at addresses stepping by 2, holding the
// core off the memory while loading.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a load (ignored unless idle)
//   base_addr, length     first write address and byte count, sampled on start
//   in_data/in_valid      stream byte and its valid
//   in_ready              loader accepts a byte this cycle
//   we, w_addr, w_instr   memory write strobe, address, {high, low} word
//   core_hold             loader busy
//   done, err             one-cycle completion pulse, length error with done
module instr_loader
  import instr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = DATA_WIDTH'(NOP)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     length,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   w_addr,
  output logic [2*DATA_WIDTH-1:0] w_instr,
  output logic                    core_hold,
  output logic                    done,
  output logic                    err
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] REM_TWO = (ADDR_WIDTH+1)'(2);

  load_state_e             state;
  load_state_e             state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [ADDR_WIDTH:0]     rem_cnt;
  logic [DATA_WIDTH-1:0]   lo_byte;
  logic                    err_flag;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    core_hold = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (length == '0 || length > MAX_LEN) state_nxt = ST_FIN;
          else                                  state_nxt = ST_LO;
        end
      end
      ST_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (rem_cnt == REM_ONE) ? ST_WRITE : ST_HI;
      end
      ST_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        we        = 1'b1;
        // At most two bytes remain means this write finishes the load.
        state_nxt = (rem_cnt <= REM_TWO) ? ST_FIN : ST_LO;
      end
      ST_FIN: begin
        done      = 1'b1;
        err       = err_flag;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_cnt <= '0;
      rem_cnt  <= '0;
      lo_byte  <= '0;
      err_flag <= 1'b0;
      w_addr   <= '0;
      w_instr  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_cnt <= base_addr;
            rem_cnt  <= length;
            err_flag <= (length > MAX_LEN);
          end
        end
        ST_LO: begin
          if (in_valid) begin
            lo_byte <= in_data;
            // Odd tail: the word is complete now, padded with PAD_BYTE.
            if (rem_cnt == REM_ONE) begin
              w_instr <= {PAD_BYTE, in_data};
              w_addr  <= addr_cnt;
            end
          end
        end
        ST_HI: begin
          if (in_valid) begin
            w_instr <= {in_data, lo_byte};
            w_addr  <= addr_cnt;
          end
        end
        ST_WRITE: begin
          addr_cnt <= addr_cnt + ADDR_WIDTH'(2);
          rem_cnt  <= (rem_cnt <= REM_TWO) ? '0 : rem_cnt - REM_TWO;
        end
        ST_FIN: begin
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

  localparam logic [7:0] PAD = 8'h22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        we;
  logic [7:0]  w_addr;
  logic [15:0] w_instr;
  logic        core_hold;
  logic        done;
  logic        err;

  instr_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .we(we), .w_addr(w_addr), .w_instr(w_instr),
    .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  logic [23:0] wq[$];
  logic [23:0] exp_q[$];
  logic [7:0]  stim_q[$];

  typedef struct {
    int          base;
    int          len;
    int          gap;
    logic [31:0] bytes;
    int          nw;
    logic [23:0] e0;
    logic [23:0] e1;
    bit          eerr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor: record every memory write and check the strobe-cycle rules.
  always @(negedge clk) begin
    if (rst_n && we) begin
      wq.push_back({w_addr, w_instr});
      last_we_cyc = cyc;
      chk("in_ready in WRITE", in_ready, 0);
      chk("core_hold in WRITE", core_hold, 1);
    end
    if (rst_n && done) chk("in_ready in FIN", in_ready, 0);
  end

  task automatic do_start(input int base, input int len);
    base_addr = 8'(base);
    length    = 9'(len);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic stream(input int n, input int gap, input bit poke);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < n) begin
      if (guard++ > 4000) begin
        chk("stream timeout", 0, 1);
        break;
      end
      in_valid = ($urandom_range(0, 99) >= gap);
      in_data  = in_valid ? stim_q[idx] : 8'($urandom);
      start    = poke;
      if (poke) begin
        base_addr = 8'($urandom);
        length    = 9'd2;
      end
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Reference: bytes pair up little-endian, odd tail padded, address steps by 2 mod 256.
  task automatic build_expected(input int base, input int len);
    logic [7:0] lo, hi;
    exp_q.delete();
    if (len <= 256) begin
      for (int i = 0; i < len; i += 2) begin
        lo = stim_q[i];
        hi = (i + 1 < len) ? stim_q[i+1] : PAD;
        exp_q.push_back({8'((base + i) % 256), hi, lo});
      end
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " write count"}, wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      chk($sformatf("%s write %0d", tag, i), wq[i], exp_q[i]);
  endtask

  task automatic run_load(input int base, input int len, input int gap, input bit poke, input string tag);
    int n;
    int lat;
    bit got;
    wq.delete();
    n = (len > 256) ? 0 : len;
    do_start(base, len);
    chk({tag, " core_hold after start"}, core_hold, 1);
    if (n > 0) chk({tag, " in_ready after start"}, in_ready, 1);
    stream(n, gap, poke);
    got = 0;
    lat = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        got = 1;
        break;
      end
      lat++;
      @(negedge clk);
    end
    chk({tag, " done seen"}, got, 1);
    if (got) begin
      chk({tag, " err"}, err, (len > 256));
      if (n == 0) chk({tag, " done latency"}, lat, 0);
      else        chk({tag, " done after last we"}, cyc - last_we_cyc, 1);
      @(negedge clk);
      chk({tag, " done one cycle"}, done, 0);
      chk({tag, " core_hold released"}, core_hold, 0);
    end
    check_writes(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0,     4,   0, 32'h04020018, 2, 24'h000018, 24'h020402, 0};
    tbl[1] = '{0,     4,  60, 32'h04020018, 2, 24'h000018, 24'h020402, 0};
    tbl[2] = '{'h10,  3,   0, 32'h001C0D0F, 2, 24'h100D0F, 24'h12221C, 0};
    tbl[3] = '{'hFF,  4,  30, 32'h44332211, 2, 24'hFF2211, 24'h014433, 0};
    tbl[4] = '{'h30,  0,   0, 32'h0,        0, 24'h0,      24'h0,      0};
    tbl[5] = '{'h30,  257, 0, 32'h0,        0, 24'h0,      24'h0,      1};
    tbl[6] = '{7,     1,   0, 32'h000000AB, 1, 24'h0722AB, 24'h0,      0};

    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset we", we, 0);
    chk("reset w_addr", w_addr, 0);
    chk("reset w_instr", w_instr, 0);
    chk("reset core_hold", core_hold, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      stim_q.delete();
      for (int i = 0; i < tbl[v].len && i < 4; i++) stim_q.push_back(tbl[v].bytes[8*i +: 8]);
      exp_q.delete();
      if (tbl[v].nw > 0) exp_q.push_back(tbl[v].e0);
      if (tbl[v].nw > 1) exp_q.push_back(tbl[v].e1);
      run_load(tbl[v].base, tbl[v].len, tbl[v].gap, 0, $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d expected err", v), (tbl[v].len > 256), tbl[v].eerr);
    end

    // start pulsed continuously during a load must be ignored
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_expected('h20, 6);
    run_load('h20, 6, 20, 1, "poke");

    // reset after the low byte of word 2
    stim_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    wq.delete();
    do_start('h40, 6);
    stream(3, 0, 0);
    chk("pre-reset writes", wq.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset in_ready", in_ready, 0);
    chk("mid reset we", we, 0);
    chk("mid reset w_addr", w_addr, 0);
    chk("mid reset w_instr", w_instr, 0);
    chk("mid reset core_hold", core_hold, 0);
    chk("mid reset done", done, 0);
    chk("mid reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_expected('h40, 4);
    run_load('h40, 4, 10, 0, "reload");

    // randomized loads against the reference
    for (int r = 0; r < 14; r++) begin
      int base, len, sel;
      base = $urandom_range(0, 255);
      sel  = $urandom_range(0, 9);
      case (sel)
        0:       len = 256;
        1:       len = 255;
        2:       len = $urandom_range(257, 511);
        default: len = $urandom_range(0, 24);
      endcase
      stim_q.delete();
      if (len <= 256) for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
      build_expected(base, len);
      run_load(base, len, $urandom_range(0, 60), 1'($urandom), $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
